prbs_sym_ctrl: RTL and testbench
================================

Name: prbs_sym_ctrl

Overview:
Burst controller and symbol packer for the PRBS9 bit source that feeds the equalizer test chain. It reseeds and enables one prbs9 instance, packs its serial bits MSB-first into BITS_PER_SYM-bit symbols, and delivers them over a valid/ready interface. Sequences are either fixed-length bursts or continuous streams. The PRBS bit stream is never skipped or repeated under backpressure.

Parameters:
BITS_PER_SYM, 2, bits per output symbol (1..8); first generated bit lands in the symbol MSB.
SEED, 9'h1AA, PRBS9 seed loaded at every start.
LEN_W, 16, width of burst_len and sym_count.

Ports:
clk  in  1  system clock, all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  one-cycle pulse; begins a burst when IDLE, otherwise ignored.
stop  in  1  one-cycle pulse; aborts an active burst.
burst_len  in  LEN_W  symbols per burst, sampled on the accepted start; 0 means continuous.
sym_valid  out  1  symbol available.
sym_ready  in  1  consumer accepts; a transfer occurs when sym_valid & sym_ready.
sym_data  out  BITS_PER_SYM  packed symbol.
busy  out  1  high in SEED/RUN/DRAIN.
done  out  1  one-cycle pulse when a finite burst completes normally.
sym_count  out  LEN_W  symbols accepted in the current or last burst; wraps in continuous mode.

Behaviour:
- Reset values: sym_valid=0, sym_data=0, busy=0, done=0, sym_count=0, state=IDLE, accumulator and bit count cleared. The prbs9 instance is also reset, so its lfsr holds SEED.
- FSM states: IDLE, SEED, RUN, DRAIN, DONE. State is held in one-hot flops.
- IDLE -> SEED on start & !stop; stop wins when both are asserted. On this transition, latch burst_len and clear sym_count.
- SEED lasts one cycle. It drives the prbs9 rst_n low through rst_n_prbs = ~(rst | seed_flop), taken directly from the flop, with no combinational decode. SEED -> RUN.
- RUN:
  - prbs en = !(limit_reached) & !(k==BITS_PER_SYM-1 & sym_valid & !sym_ready).
  - When en=1, bit_out is shifted into the accumulator LSB and k increments.
  - The edge that captures the last bit writes {acc, bit_out} into sym_data and sets sym_valid. That write only happens when the slot is free or being drained that cycle; this is guaranteed by the en term.
  - In the stall case, en is held on the last bit, so the lfsr is not advanced.
- limit_reached: produced==burst_len with burst_len!=0, where produced counts symbols written to the output register. On limit_reached, RUN -> DRAIN.
- DRAIN: en=0. On the final handshake, go to DONE.
- DONE lasts one cycle, pulses done, then returns to IDLE.
- Latency: the first sym_valid asserts BITS_PER_SYM+1 rising edges after the edge that samples start (3 for the default).
- Throughput: one symbol per BITS_PER_SYM cycles with sym_ready held high.
- sym_valid/sym_data hold stable until accepted.
- sym_count increments on each handshake and is frozen in IDLE.
- stop in SEED/RUN/DRAIN:
  - Next edge: sym_valid=0, accumulator and k cleared, go to IDLE.
  - No done pulse; sym_count keeps its value.
  - A handshake in the same cycle as stop still counts.
- start while busy is ignored, and burst_len is not re-sampled.
- Continuous mode (burst_len=0): never enters DRAIN; it runs until stop or rst.
- rst mid-burst: everything returns to reset values immediately and asynchronously.

Decomposition:
- Package prbs_pkg: PRBS9_SEED_DEFAULT = 9'h1AA, the FSM state index constants, and MAX_BITS_PER_SYM = 8.
- One sub-module: the existing prbs9 generator, instantiated with SEED passed through, rst_n driven as above, and en driven by the controller.
- Accumulator, counters and FSM stay flat in prbs_sym_ctrl.

Test Plan:
- Reset, then start with burst_len=5 and sym_ready=1 -> sym_data sequence 3,1,1,1,1 (bits 110101010 then 1). sym_valid first asserts 3 edges after start. done pulses once after the 5th handshake; sym_count=5; busy low afterwards.
- Same burst with sym_ready toggling 1,0,0,1,... -> identical symbol sequence 3,1,1,1,1. sym_data is stable while stalled, and no extra symbol is produced.
- burst_len=0, 600 handshakes -> the bit stream repeats with period 511. A second start is ignored; stop ends the stream within 1 cycle with done=0.
- stop asserted 2 cycles after start -> sym_valid never asserts, done=0. A new start replays the burst from 3,1,1,...
- start and stop asserted in the same IDLE cycle -> remains IDLE, busy=0.
- rst asserted mid-burst after 2 symbols, then released and restarted -> all outputs are at reset values during rst, and the new burst begins again with 3,1,1.

Source files
------------

// File: rtl/prbs_pkg.sv
// rtl/prbs_pkg.sv - shared constants and state encoding for the PRBS9 symbol controller
package prbs_pkg;

  localparam logic [8:0] PRBS9_SEED_DEFAULT = 9'h1AA;
  localparam int         MAX_BITS_PER_SYM   = 8;

  localparam int IDX_IDLE  = 0;
  localparam int IDX_SEED  = 1;
  localparam int IDX_RUN   = 2;
  localparam int IDX_DRAIN = 3;
  localparam int IDX_DONE  = 4;

  // One-hot encoding: each state owns exactly one flop, addressed by IDX_*.
  typedef enum logic [4:0] {
    ST_IDLE  = 5'(1 << IDX_IDLE),
    ST_SEED  = 5'(1 << IDX_SEED),
    ST_RUN   = 5'(1 << IDX_RUN),
    ST_DRAIN = 5'(1 << IDX_DRAIN),
    ST_DONE  = 5'(1 << IDX_DONE)
  } state_t;

endpackage

// File: rtl/prbs_sym_ctrl_if.sv
// rtl/prbs_sym_ctrl_if.sv - valid/ready symbol stream between packer and consumer
interface prbs_sym_ctrl_if #(
  parameter int BITS_PER_SYM = 2
);
  logic                    sym_valid;
  logic                    sym_ready;
  logic [BITS_PER_SYM-1:0] sym_data;

  modport master (output sym_valid, output sym_data, input  sym_ready);
  modport slave  (input  sym_valid, input  sym_data, output sym_ready);
endinterface

// File: rtl/prbs9.sv
// rtl/prbs9.sv - PRBS9 (x^9 + x^5 + 1) serial bit source, MSB of the lfsr is the output bit
module prbs9
  import prbs_pkg::*;
#(
  parameter logic [8:0] SEED = PRBS9_SEED_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_out
);

  logic [8:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= SEED;
    end else if (en) begin
      lfsr <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    end
  end

  assign bit_out = lfsr[8];

endmodule

// File: rtl/prbs_sym_ctrl.sv
// rtl/prbs_sym_ctrl.sv - reseeds a prbs9, packs its bits MSB-first into symbols, bursts or streams
module prbs_sym_ctrl
  import prbs_pkg::*;
#(
  parameter int         BITS_PER_SYM = 2,
  parameter logic [8:0] SEED         = PRBS9_SEED_DEFAULT,
  parameter int         LEN_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [LEN_W-1:0]   burst_len,
  prbs_sym_ctrl_if.master    sym,
  output logic               busy,
  output logic               done,
  output logic [LEN_W-1:0]   sym_count
);

  localparam int               K_W    = $clog2(MAX_BITS_PER_SYM) + 1;
  localparam logic [K_W-1:0]   K_LAST = K_W'(BITS_PER_SYM - 1);

  state_t                  state_q, state_d;
  logic [LEN_W-1:0]        burst_len_q;
  logic [LEN_W-1:0]        produced;
  logic [BITS_PER_SYM-1:0] acc;
  logic [K_W-1:0]          k;
  logic [BITS_PER_SYM:0]   shifted;
  logic                    bit_out, en, rst_n_prbs;
  logic                    handshake, last_bit, limit_reached, accept_start;

  // The seed flop itself drives the generator reset so the pulse is glitch-free.
  assign rst_n_prbs    = ~(rst | state_q[IDX_SEED]);
  assign handshake     = sym.sym_valid & sym.sym_ready;
  assign last_bit      = (k == K_LAST);
  assign limit_reached = (burst_len_q != '0) && (produced == burst_len_q);
  assign accept_start  = state_q[IDX_IDLE] & start & ~stop;
  assign shifted       = {acc, bit_out};
  assign busy          = state_q[IDX_SEED] | state_q[IDX_RUN] | state_q[IDX_DRAIN];
  assign done          = state_q[IDX_DONE];

  // Holding en on a stalled last bit keeps the lfsr from advancing past unsent data.
  assign en = state_q[IDX_RUN] & ~limit_reached
            & ~(last_bit & sym.sym_valid & ~sym.sym_ready);

  prbs9 #(.SEED(SEED)) u_prbs9 (
    .clk     (clk),
    .rst_n   (rst_n_prbs),
    .en      (en),
    .bit_out (bit_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start && !stop) state_d = ST_SEED;
      ST_SEED:  state_d = stop ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (stop)               state_d = ST_IDLE;
        else if (limit_reached) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (stop)                                  state_d = ST_IDLE;
        else if (!sym.sym_valid || sym.sym_ready)  state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym.sym_valid <= 1'b0;
      sym.sym_data  <= '0;
      sym_count     <= '0;
      produced      <= '0;
      burst_len_q   <= '0;
      acc           <= '0;
      k             <= '0;
    end else if (accept_start) begin
      burst_len_q <= burst_len;
      sym_count   <= '0;
      produced    <= '0;
      acc         <= '0;
      k           <= '0;
    end else if (busy && stop) begin
      sym.sym_valid <= 1'b0;
      acc           <= '0;
      k             <= '0;
      if (handshake) sym_count <= sym_count + 1'b1;
    end else begin
      if (handshake && busy) sym_count <= sym_count + 1'b1;
      if (handshake)         sym.sym_valid <= 1'b0;
      if (en) begin
        if (last_bit) begin
          sym.sym_data  <= shifted[BITS_PER_SYM-1:0];
          sym.sym_valid <= 1'b1;
          acc           <= '0;
          k             <= '0;
          produced      <= produced + 1'b1;
        end else begin
          acc <= shifted[BITS_PER_SYM-1:0];
          k   <= k + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_prbs_sym_ctrl.sv
// tb/tb_prbs_sym_ctrl.sv - directed self-checking bench for prbs_sym_ctrl
module tb_prbs_sym_ctrl;

  localparam int BPS   = 2;
  localparam int LEN_W = 16;

  logic             clk = 1'b0;
  logic             rst, start, stop;
  logic [LEN_W-1:0] burst_len;
  logic             busy, done;
  logic [LEN_W-1:0] sym_count;

  prbs_sym_ctrl_if #(.BITS_PER_SYM(BPS)) sym_if ();

  prbs_sym_ctrl #(.BITS_PER_SYM(BPS), .SEED(9'h1AA), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .burst_len (burst_len),
    .sym       (sym_if),
    .busy      (busy),
    .done      (done),
    .sym_count (sym_count)
  );

  always #5 clk = ~clk;

  int             n_checks = 0;
  int             n_fail   = 0;
  int             done_cnt, stall_err, first_valid;
  bit             busy_seen;
  logic [BPS-1:0] got[$];
  logic [BPS-1:0] exp5[5] = '{2'd3, 2'd1, 2'd1, 2'd1, 2'd1};

  task automatic clr();
    got.delete();
    done_cnt    = 0;
    stall_err   = 0;
    first_valid = -1;
    busy_seen   = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1 repeating.
  task automatic consume(input int cycles, input int mode, input int start_at,
                         input int stop_at, input int max_sym);
    bit             prev_stall = 1'b0;
    logic [BPS-1:0] prev_data  = '0;
    for (int cyc = 1; cyc <= cycles; cyc++) begin
      @(negedge clk);
      start = (cyc == start_at);
      stop  = (cyc == stop_at);
      sym_if.sym_ready = (mode == 0) ? 1'b1 : ((((cyc - 1) % 4) == 0) || (((cyc - 1) % 4) == 3));
      if (done) done_cnt++;
      if (busy) busy_seen = 1'b1;
      if (prev_stall && (!sym_if.sym_valid || sym_if.sym_data !== prev_data)) stall_err++;
      if (sym_if.sym_valid && first_valid < 0) first_valid = cyc;
      prev_stall = sym_if.sym_valid && !sym_if.sym_ready;
      prev_data  = sym_if.sym_data;
      if (sym_if.sym_valid && sym_if.sym_ready) begin
        got.push_back(sym_if.sym_data);
        if (got.size() >= max_sym) break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; burst_len = '0; sym_if.sym_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (sym_if.sym_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0d want 0", sym_if.sym_valid); end
    n_checks++; if (sym_if.sym_data !== 2'd0) begin n_fail++; $display("FAIL reset_data: got %0d want 0", sym_if.sym_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0d want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0d want 0", done); end
    n_checks++; if (sym_count !== 16'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", sym_count); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_burst5(input string tag);
    n_checks++; if (got.size() != 5) begin n_fail++; $display("FAIL %s_nsym: got %0d want 5", tag, got.size()); end
    for (int i = 0; i < 5 && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp5[i]) begin n_fail++; $display("FAIL %s_sym%0d: got %0d want %0d", tag, i, got[i], exp5[i]); end
    end
  endtask

  task automatic test_burst();
    clr(); burst_len = 16'd5;
    consume(60, 0, 1, 0, 1000);
    check_burst5("burst");
    n_checks++; if (first_valid - 2 != 3) begin n_fail++; $display("FAIL burst_latency: got %0d want 3", first_valid - 2); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL burst_done: got %0d pulses want 1", done_cnt); end
    n_checks++; if (sym_count !== 16'd5) begin n_fail++; $display("FAIL burst_count: got %0d want 5", sym_count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_busy_end: got %0d want 0", busy); end
  endtask

  task automatic test_backpressure();
    clr(); burst_len = 16'd5;
    consume(80, 1, 1, 0, 1000);
    check_burst5("bp");
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable cycles want 0", stall_err); end
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done: got %0d pulses want 1", done_cnt); end
    n_checks++; if (sym_count !== 16'd5) begin n_fail++; $display("FAIL bp_count: got %0d want 5", sym_count); end
  endtask

  task automatic test_continuous();
    logic [8:0] lfsr;
    bit         bits[1600];
    bit         gb[$];
    int         per_err;
    lfsr = 9'h1AA;
    for (int i = 0; i < 1600; i++) begin
      bits[i] = lfsr[8];
      lfsr    = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    end
    clr(); burst_len = 16'd0;
    consume(1600, 0, 1, 0, 600);
    n_checks++; if (got.size() != 600) begin n_fail++; $display("FAIL cont_nsym: got %0d want 600", got.size()); end
    burst_len = 16'd3;
    consume(30, 0, 3, 0, 100000);
    for (int i = 0; i < got.size() && 2 * i + 1 < 1600; i++) begin
      n_checks++;
      if (got[i] !== {bits[2*i], bits[2*i+1]}) begin
        n_fail++; $display("FAIL cont_sym%0d: got %0d want %0d", i, got[i], {bits[2*i], bits[2*i+1]});
      end
    end
    foreach (got[i]) begin gb.push_back(got[i][1]); gb.push_back(got[i][0]); end
    per_err = 0;
    for (int j = 0; j + 511 < gb.size(); j++) if (gb[j] != gb[j+511]) per_err++;
    n_checks++; if (per_err != 0) begin n_fail++; $display("FAIL cont_period511: got %0d bit diffs want 0", per_err); end
    @(negedge clk);
    sym_if.sym_ready = 1'b0; stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    if (done) done_cnt++;
    n_checks++; if (sym_if.sym_valid !== 1'b0) begin n_fail++; $display("FAIL cont_stop_valid: got %0d want 0", sym_if.sym_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_stop_busy: got %0d want 0", busy); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL cont_done: got %0d pulses want 0", done_cnt); end
    n_checks++; if (sym_count !== 16'(got.size())) begin n_fail++; $display("FAIL cont_count: got %0d want %0d", sym_count, got.size()); end
  endtask

  task automatic test_stop_early();
    clr(); burst_len = 16'd5;
    consume(20, 0, 1, 3, 1000);
    n_checks++; if (first_valid != -1) begin n_fail++; $display("FAIL stop_valid: got first valid at cycle %0d want never", first_valid); end
    n_checks++; if (done_cnt != 0) begin n_fail++; $display("FAIL stop_done: got %0d pulses want 0", done_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_busy: got %0d want 0", busy); end
    clr();
    consume(60, 0, 1, 0, 1000);
    check_burst5("replay");
  endtask

  task automatic test_start_stop_same();
    clr(); burst_len = 16'd5;
    consume(10, 0, 1, 1, 1000);
    n_checks++; if (busy_seen !== 1'b0) begin n_fail++; $display("FAIL ss_busy: got %0d want 0", busy_seen); end
    n_checks++; if (first_valid != -1) begin n_fail++; $display("FAIL ss_valid: got cycle %0d want never", first_valid); end
  endtask

  task automatic test_rst_mid();
    clr(); burst_len = 16'd5;
    consume(60, 0, 1, 0, 2);
    n_checks++; if (got.size() != 2 || got[0] !== 2'd3 || got[1] !== 2'd1) begin n_fail++; $display("FAIL rst_pre: got %0d symbols want 3,1", got.size()); end
    rst = 1'b1;
    #1;
    n_checks++; if (sym_if.sym_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0d want 0", sym_if.sym_valid); end
    n_checks++; if (sym_if.sym_data !== 2'd0) begin n_fail++; $display("FAIL rst_data: got %0d want 0", sym_if.sym_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0d want 0", busy); end
    n_checks++; if (sym_count !== 16'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", sym_count); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0d want 0", done); end
    rst = 1'b0;
    clr();
    consume(60, 0, 1, 0, 1000);
    check_burst5("rst_restart");
    n_checks++; if (done_cnt != 1) begin n_fail++; $display("FAIL rst_restart_done: got %0d pulses want 1", done_cnt); end
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_burst();
    test_backpressure();
    test_continuous();
    test_stop_early();
    test_start_stop_same();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
